// File: rtl/phy_pkg.sv
// Shared PHY constants: comma character, sync length and serializer/deserializer state encoding.
package phy_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BIT_CNT_W  = 3;
    localparam int unsigned COM_CNT_W  = 3;

    localparam logic [BYTE_W-1:0] COM_CHAR_DEFAULT   = 8'hBC;
    localparam int unsigned       SYNC_COUNT_DEFAULT = 4;

    // Link state encoding, kept as plain constants for compatibility with older tools
    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

endpackage

// File: rtl/paralelo_serial.sv
// Byte-to-bit serializer: sends a comma preamble after reset, then user bytes MSB first,
// filling idle byte slots with the comma character.
module paralelo_serial
    import phy_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COM_CHAR   = COM_CHAR_DEFAULT,
    parameter int unsigned       SYNC_COUNT = SYNC_COUNT_DEFAULT
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              sync_done
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(7);
    localparam logic [COM_CNT_W-1:0] SYNC_LIMIT = COM_CNT_W'(SYNC_COUNT);

    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [BYTE_W-1:0]    shreg, shreg_nxt;
    logic [COM_CNT_W-1:0] com_cnt, com_cnt_nxt;
    logic [0:0]           state, state_nxt;
    logic                 sync_done_nxt;
    logic                 ready_nxt;
    logic                 load_slot;

    // Next-state logic: bit counter, shift/load of the byte register and SYNC->DATA progression
    always_comb begin
        bit_cnt_nxt   = bit_cnt + BIT_CNT_W'(1);
        shreg_nxt     = {shreg[BYTE_W-2:0], 1'b0};
        com_cnt_nxt   = com_cnt;
        state_nxt     = state;
        sync_done_nxt = sync_done;
        load_slot     = (bit_cnt == LAST_BIT);

        if (load_slot) begin
            case (state)
                ST_SYNC: begin
                    shreg_nxt   = COM_CHAR;
                    com_cnt_nxt = com_cnt + COM_CNT_W'(1);
                    if (com_cnt_nxt == SYNC_LIMIT) begin
                        state_nxt     = ST_DATA;
                        sync_done_nxt = 1'b1;
                    end
                end
                default: begin
                    shreg_nxt = valid_in ? data_in : COM_CHAR;
                end
            endcase
        end

        // Slot-open flag is a function of state and bit position only, never of valid_in
        ready_nxt = (state_nxt == ST_DATA) && (bit_cnt_nxt == LAST_BIT);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            com_cnt   <= '0;
            state     <= ST_SYNC;
            sync_done <= 1'b0;
            ready_out <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            com_cnt   <= com_cnt_nxt;
            state     <= state_nxt;
            sync_done <= sync_done_nxt;
            ready_out <= ready_nxt;
        end
    end

    assign data_out = shreg[BYTE_W-1];

endmodule
